// File: rtl/vga_pmod_formatter.sv
// vga_pmod_formatter: registered VGA output stage feeding the PMOD pins.
// Maps logical sync/colour onto four pinout modes, reduces colour depth to
// 2 bits per channel, and only switches mode on a vsync rise so that frames
// never tear. Optional ordered dithering is enabled with `define VGA_DITHER_EN.
module vga_pmod_formatter #(
    parameter int IN_BITS     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SYNC_NEG    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode_sel,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   blank_in,
    input  logic                   x0,
    input  logic                   y0,
    input  logic [3*IN_BITS-1:0]   rgb_in,
    output logic [7:0]             uo_out,
    output logic [1:0]             mode_active,
    output logic                   mode_change
);

    localparam logic SNEG = (SYNC_NEG != 0);
    localparam logic [7:0] UO_RESET = {SNEG, 3'b000, SNEG, 3'b000};

    logic [1:0] sync_reg [SYNC_STAGES];
    logic [1:0] pend;
    logic       vsync_prev_reg;
    logic       f_reg;
    logic [1:0] mode_active_reg;
    logic       mode_change_reg;
    logic [7:0] uo_out_reg;

    logic       vs_rise;
    logic [1:0] mode_eff;
    logic [1:0] chan [3];
    logic [1:0] col_r, col_g, col_b;
    logic       hs_pin, vs_pin;
    logic [7:0] uo_out_next;

    // First synchroniser stage captures the asynchronous mode request.
    always_ff @(posedge clk) begin
        if (reset) sync_reg[0] <= 2'b00;
        else       sync_reg[0] <= mode_sel;
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            // Remaining synchroniser stages shift the request toward pend.
            always_ff @(posedge clk) begin
                if (reset) sync_reg[gi] <= 2'b00;
                else       sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign pend     = sync_reg[SYNC_STAGES-1];
    assign vs_rise  = vsync_in & ~vsync_prev_reg;
    // The pixel clocked at the vsync rise already belongs to the new frame.
    assign mode_eff = vs_rise ? pend : mode_active_reg;

`ifdef VGA_DITHER_EN
    // 2x2 Bayer threshold in quarter units; f flips the x phase each frame.
    logic [1:0] bayer_idx;
    logic [1:0] thr;
    assign bayer_idx = {y0, x0 ^ f_reg};
    always_comb begin
        thr = 2'd0;
        case (bayer_idx)
            2'b00:   thr = 2'd0;
            2'b01:   thr = 2'd2;
            2'b10:   thr = 2'd3;
            default: thr = 2'd1;
        endcase
    end
`else
    logic unused_pos;
    assign unused_pos = ^{x0, y0};
`endif

    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [IN_BITS-1:0] v;
            assign v = rgb_in[(3-gi)*IN_BITS-1 -: IN_BITS];
            if (IN_BITS == 2) begin : g_pass
                assign chan[gi] = v;
            end else begin : g_reduce
`ifdef VGA_DITHER_EN
                localparam int D = IN_BITS - 2;
                logic [D-1:0] lo;
                logic [D-1:0] ts;
                logic         bump;
                logic [2:0]   sum;
                assign lo = v[D-1:0];
                if (D == 1) begin : g_t1
                    assign ts = thr[1];
                end else begin : g_t2
                    assign ts = thr;
                end
                assign bump     = (lo > ts);
                assign sum      = {1'b0, v[IN_BITS-1 -: 2]} + {2'b00, bump};
                assign chan[gi] = sum[2] ? 2'b11 : sum[1:0];
`else
                logic unused_lo;
                assign unused_lo = ^v[IN_BITS-3:0];
                assign chan[gi]  = v[IN_BITS-1 -: 2];
`endif
            end
        end
    endgenerate

    // Colour override (blanking, white field) and pin mapping for the next output word.
    always_comb begin
        col_r       = chan[0];
        col_g       = chan[1];
        col_b       = chan[2];
        hs_pin      = hsync_in ^ SNEG ^ (mode_eff == 2'd2);
        vs_pin      = vsync_in ^ SNEG ^ (mode_eff == 2'd2);
        uo_out_next = 8'h00;
        if (blank_in) begin
            col_r = 2'b00;
            col_g = 2'b00;
            col_b = 2'b00;
        end else if (mode_eff == 2'd3) begin
            col_r = 2'b11;
            col_g = 2'b11;
            col_b = 2'b11;
        end
        if (mode_eff == 2'd1)
            uo_out_next = {col_r[1], col_r[0], col_g[1], col_g[0],
                           col_b[1], col_b[0], vs_pin, hs_pin};
        else
            uo_out_next = {hs_pin, col_b[0], col_g[0], col_r[0],
                           vs_pin, col_b[1], col_g[1], col_r[1]};
    end

    // Output register, frame-boundary mode switch and frame parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            uo_out_reg      <= UO_RESET;
            mode_active_reg <= 2'b00;
            mode_change_reg <= 1'b0;
            f_reg           <= 1'b0;
            vsync_prev_reg  <= 1'b0;
        end else begin
            uo_out_reg      <= uo_out_next;
            vsync_prev_reg  <= vsync_in;
            mode_change_reg <= vs_rise && (pend != mode_active_reg);
            mode_active_reg <= mode_eff;
            if (vs_rise) f_reg <= ~f_reg;
        end
    end

    assign uo_out      = uo_out_reg;
    assign mode_active = mode_active_reg;
    assign mode_change = mode_change_reg;

endmodule

// File: tb/tb_vga_pmod_formatter.sv
// Scoreboard bench for vga_pmod_formatter: the driver pushes the expected
// registered outputs from a behavioural model, a monitor pops and compares.
module tb_vga_pmod_formatter;

    localparam int IN_BITS = 4;
    localparam int STAGES  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [1:0]           mode_sel = 2'd0;
    logic                 hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0;
    logic                 x0 = 1'b0, y0 = 1'b0;
    logic [3*IN_BITS-1:0] rgb_in = '0;
    logic [7:0]           uo_out;
    logic [1:0]           mode_active;
    logic                 mode_change;

    vga_pmod_formatter #(.IN_BITS(IN_BITS), .SYNC_STAGES(STAGES), .SYNC_NEG(1)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .blank_in(blank_in), .x0(x0), .y0(y0), .rgb_in(rgb_in),
        .uo_out(uo_out), .mode_active(mode_active), .mode_change(mode_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] uo;
        logic [1:0] ma;
        logic       mc;
    } exp_t;

    exp_t exp_q[$];
    int   pend_q[$];
    int   m_mode = 0, m_f = 0, m_prev_vs = 0;
    int   vectors = 0, miscompares = 0, change_pulses = 0;
    bit   verbose = 1'b1;

    // Expected 2-bit channel value from the colour-reduction rules.
    function automatic int reduce(int v, int x, int y, int f);
        int d;
        d = IN_BITS - 2;
`ifdef VGA_DITHER_EN
        begin
            int bayer[4];
            int hi, lo, t, ts, r;
            bayer = '{0, 2, 3, 1};
            hi = v >> d;
            lo = v % (1 << d);
            t  = bayer[y * 2 + (x ^ f)];
            ts = (d == 2) ? t : (d == 1) ? t / 2 : 0;
            r  = hi + ((d > 0 && lo > ts) ? 1 : 0);
            return (r > 3) ? 3 : r;
        end
`else
        return v >> d;
`endif
    endfunction

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("chk %s ok: %0h", name, got);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic drive(input bit rst, input int ms, input bit hs, input bit vs,
                         input bit bl, input bit x, input bit y, input int rgb);
        exp_t e;
        int   pend, c[3], hsp, vsp, uo;
        bit   rise;
        @(negedge clk);
        reset = rst; mode_sel = 2'(ms); hsync_in = hs; vsync_in = vs;
        blank_in = bl; x0 = x; y0 = y; rgb_in = (3*IN_BITS)'(rgb);
        if (rst) begin
            e.uo = 8'h88; e.ma = 2'd0; e.mc = 1'b0;
            m_mode = 0; m_f = 0; m_prev_vs = 0;
            pend_q.delete();
            for (int i = 0; i < STAGES; i++) pend_q.push_back(0);
        end else begin
            pend = pend_q[0];
            rise = vs && (m_prev_vs == 0);
            e.mc = 1'b0;
            if (rise && pend != m_mode) begin
                m_mode = pend;
                e.mc   = 1'b1;
            end
            for (int ch = 0; ch < 3; ch++) begin
                int v;
                v = (rgb >> ((2 - ch) * IN_BITS)) & ((1 << IN_BITS) - 1);
                c[ch] = bl ? 0 : (m_mode == 3) ? 3 : reduce(v, x, y, m_f);
            end
            if (rise) m_f ^= 1;
            m_prev_vs = vs;
            hsp = (hs ? 1 : 0) ^ 1 ^ ((m_mode == 2) ? 1 : 0);
            vsp = (vs ? 1 : 0) ^ 1 ^ ((m_mode == 2) ? 1 : 0);
            if (m_mode == 1)
                uo = c[0] * 64 + c[1] * 16 + c[2] * 4 + vsp * 2 + hsp;
            else
                uo = hsp * 128 + (c[2] % 2) * 64 + (c[1] % 2) * 32 + (c[0] % 2) * 16
                   + vsp * 8 + (c[2] / 2) * 4 + (c[1] / 2) * 2 + (c[0] / 2);
            e.uo = 8'(uo);
            e.ma = 2'(m_mode);
            void'(pend_q.pop_front());
            pend_q.push_back(ms);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mode_change === 1'b1) change_pulses++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({uo_out, mode_active, mode_change} !== e) begin
                    miscompares++;
                    $display("FAIL out: got uo=%h ma=%0d mc=%b want uo=%h ma=%0d mc=%b",
                             uo_out, mode_active, mode_change, e.uo, e.ma, e.mc);
                end else if (verbose) begin
                    $display("txn uo=%h ma=%0d mc=%b", uo_out, mode_active, mode_change);
                end
            end
        end
    end

    initial begin
        int pulses0, cnt, ms, glitch, rst_at;
        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_uo", uo_out, 8'h88);
        check("reset_mode", mode_active, 0);

        // Mode 0, full red, hsync active.
        drive(0, 0, 1, 0, 0, 0, 0, 12'hF00);
        @(posedge clk); #1;
        check("red_hs", uo_out, 8'h19);

        // Request mode 1 mid-frame; it must wait for the vsync rise.
        pulses0 = change_pulses;
        for (int i = 0; i < 20; i++)
            drive(0, 1, (i % 5) == 0, 0, 0, i % 2, 0, int'($urandom_range(0, 4095)));
        @(posedge clk); #1;
        check("no_early_switch", mode_active, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 12'h5A3);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0, 1, 1, 12'h0F0);
        check("switched_mode1", mode_active, 1);
        check("one_pulse", change_pulses - pulses0, 1);

        // Glitch to mode 2 for 100 clocks, gone before the next vsync rise.
        pulses0 = change_pulses;
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0, 0, 12'h123);
        for (int i = 0; i < 100; i++)
            drive(0, 2, (i % 7) == 0, 0, i % 3 == 0, i % 2, (i / 2) % 2, int'($urandom_range(0, 4095)));
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0, 0, 12'h321);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0, 0, 0, 12'hABC);
        check("glitch_mode", mode_active, 1);
        check("glitch_pulses", change_pulses - pulses0, 0);

        // White-field mode with blanking: colour pins off, syncs still follow.
        for (int i = 0; i < 4; i++) drive(0, 3, 0, 0, 0, 0, 0, 12'h000);
        drive(0, 3, 0, 1, 0, 0, 0, 12'h000);
        drive(0, 3, 1, 1, 1, 0, 0, 12'hFFF);
        @(posedge clk); #1;
        check("blank_colour", uo_out & 8'h77, 0);
        check("blank_sync", uo_out & 8'h88, 8'h00);
        drive(0, 3, 0, 0, 1, 1, 1, 12'hFFF);
        @(posedge clk); #1;
        check("blank_sync_idle", uo_out, 8'h88);
        drive(0, 3, 0, 0, 0, 0, 0, 12'h000);
        @(posedge clk); #1;
        check("white_field", uo_out, 8'hFF);

        // 2x2 dither pattern at f=0 after a reset (only meaningful with dithering).
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++)
            drive(0, 0, 0, 0, 0, p % 2, p / 2, 12'hA00);
        for (int p = 0; p < 4; p++)
            drive(0, 0, 0, 0, 0, p % 2, p / 2, 12'hF00);

        // Randomised frames with occasional mode requests, glitches and one reset.
        verbose = 1'b0;
        ms = 0; glitch = 0;
        rst_at = int'($urandom_range(500, 2500));
        for (cnt = 0; cnt < 3000; cnt++) begin
            int fp;
            fp = cnt % 64;
            if ($urandom_range(0, 149) == 0) ms = int'($urandom_range(0, 3));
            glitch = ($urandom_range(0, 99) == 0) ? int'($urandom_range(0, 3)) : -1;
            drive(cnt == rst_at, (glitch >= 0) ? glitch : ms, (cnt % 8) < 1,
                  fp >= 2 && fp < 5, (cnt % 8) >= 6 || fp < 6,
                  cnt % 2, (cnt / 8) % 2, int'($urandom_range(0, 4095)));
        end
        drive(0, ms, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk); #2;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
